// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared states, encodings and per-state control table for the multicycle controller
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class; FUNCT defers to the funct3/funct7b5 decoder
    typedef enum logic [1:0] {
        ASEL_ADD,
        ASEL_SUB,
        ASEL_FUNCT
    } alu_sel_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        alu_sel_t   alu_sel;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c.pc_write   = 1'b0;
        c.ir_write   = 1'b0;
        c.mem_write  = 1'b0;
        c.reg_write  = 1'b0;
        c.adr_src    = 1'b0;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_REGB;
        c.result_src = RES_ALUOUT;
        c.alu_sel    = ASEL_ADD;
        c.branch     = 1'b0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR1: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_REGB;
                c.alu_sel   = ASEL_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_IMM;
                c.alu_sel   = ASEL_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_REGB;
                c.alu_sel   = ASEL_SUB;
                c.branch    = 1'b1;
            end
            S_JAL, S_JALR2: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMMEXT;
                c.reg_write  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - funct3/funct7b5 to ALUControl mapping for R- and I-type ALU ops
module riscv_alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_control
);

    // funct7b5 only selects sub for register-register ops; in addi it is an immediate bit
    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            3'b100:  alu_control = ALU_XOR;
            3'b010:  alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multicycle RV32 control FSM driving datapath selects and write enables
module riscv_mc_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [2:0] Imm_Src,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl;
    logic       taken;
    logic [2:0] funct_alu;

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR1;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECR:   next_state = S_ALUWB;
            S_EXECI:   next_state = S_ALUWB;
            S_JAL:     next_state = S_ALUWB;
            S_JALR1:   next_state = S_JALR2;
            S_JALR2:   next_state = S_ALUWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state, loaded from the table for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state);
        end
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: taken = 1'b0;
        endcase
    end

    riscv_alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (state == S_EXECR),
        .alu_control (funct_alu)
    );

    // While reset is asserted the outputs show FETCH selects with every enable held off
    always_comb begin
        ctrl       = rst ? state_ctrl(S_FETCH) : ctrl_q;
        PCWrite    = !rst && (ctrl.pc_write || (ctrl.branch && taken));
        IRWrite    = !rst && ctrl.ir_write;
        MemWrite   = !rst && ctrl.mem_write;
        RegWrite   = !rst && ctrl.reg_write;
        AdrSrc     = ctrl.adr_src;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ResultSrc  = ctrl.result_src;
        case (ctrl.alu_sel)
            ASEL_SUB:   ALUControl = ALU_SUB;
            ASEL_FUNCT: ALUControl = funct_alu;
            default:    ALUControl = ALU_ADD;
        endcase
        Imm_Src    = imm_src_of(opcode);
        illegal_op = !rst && (state == S_DECODE) && !is_known_op(opcode);
    end

endmodule

// File: doc/riscv_mc_controller.md
RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 7 bits: instruction register bits [6:0].
REQ-004 SHALL have port funct3, input, 3 bits: instruction register bits [14:12].
REQ-005 SHALL have port funct7b5, input, 1 bit: instruction register bit 30.
REQ-006 SHALL have port zero, input, 1 bit: ALU result equals zero.
REQ-007 SHALL have port lt, input, 1 bit: ALU signed less-than.
REQ-008 SHALL have output ports, each a write enable:
- PCWrite, 1 bit.
- IRWrite, 1 bit.
- MemWrite, 1 bit.
- RegWrite, 1 bit.
REQ-009 SHALL have port AdrSrc, output, 1 bit: 0 = PC, 1 = Result.
REQ-010 SHALL have ports ALUSrcA and ALUSrcB, outputs, 2 bits each.
- ALUSrcA: 00 = PC, 01 = OldPC, 10 = RegA.
- ALUSrcB: 00 = RegB, 01 = ImmExt, 10 = constant 4.
REQ-011 SHALL have port ResultSrc, output, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
REQ-012 SHALL have port ALUControl, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-013 SHALL have port Imm_Src, output, 3 bits: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-014 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-015 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI.
REQ-016 SHALL, in FETCH, drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-017 SHALL, in DECODE, drive ALUSrcA=01, ALUSrcB=01 and add to form the branch/jal target, then dispatch on opcode:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 1100111 -> JALR1.
- 0110111 -> LUI.
- Any other opcode -> FETCH with illegal_op=1 for that cycle.
REQ-018 SHALL, in MEMADR, drive ALUSrcA=10, ALUSrcB=01 and add, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-019 SHALL, in MEMREAD, drive ResultSrc=00 and AdrSrc=1 (-> MEMWB).
REQ-020 SHALL, in MEMWB, drive ResultSrc=01 and RegWrite=1 (-> FETCH).
REQ-021 SHALL, in MEMWRITE, drive ResultSrc=00, AdrSrc=1 and MemWrite=1 (-> FETCH).
REQ-022 SHALL, in EXECR, drive ALUSrcA=10 and ALUSrcB=00 (-> ALUWB); in EXECI, drive ALUSrcA=10 and ALUSrcB=01 (-> ALUWB).
REQ-023 SHALL, in ALUWB, drive ResultSrc=00 and RegWrite=1 (-> FETCH).
REQ-024 SHALL decode ALUControl in EXECR/EXECI from funct3 as follows:
- 000: sub only when EXECR and funct7b5=1, otherwise add.
- 111: and.
- 110: or.
- 100: xor.
- 010: slt.
- Any other value: add.
REQ-025 SHALL, in BRANCH, drive ALUSrcA=10, ALUSrcB=00, sub and ResultSrc=00, with PCWrite=taken, then go to FETCH. Taken by funct3:
- 000: zero.
- 001: !zero.
- 100: lt.
- 101: !lt.
- Any other value: 0.
REQ-026 SHALL, in JAL, drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1 (-> ALUWB).
REQ-027 SHALL, in JALR1, drive ALUSrcA=10, ALUSrcB=01 and add (-> JALR2).
REQ-028 SHALL, in JALR2, drive the JAL outputs (-> ALUWB).
REQ-029 SHALL, in LUI, drive ResultSrc=11 and RegWrite=1 (-> FETCH).
REQ-030 SHALL drive Imm_Src combinationally from opcode in every state:
- 0100011 -> 001.
- 1100011 -> 010.
- 0110111 -> 011.
- 1101111 -> 100.
- Any other opcode -> 000.
REQ-031 SHALL drive every output not named for a state to 0 in that state.
REQ-032 SHALL meet these cycle counts, FETCH to next FETCH: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, illegal 2.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, enter FETCH regardless of current state, including mid-instruction.
REQ-034 SHALL hold PCWrite, IRWrite, MemWrite, RegWrite and illegal_op at 0 while rst=1.
REQ-035 SHALL hold all other outputs at their FETCH values while rst=1.

Structure
REQ-036 SHALL place in shared package riscv_mc_pkg: the state enum, opcode constants, ALUControl, Imm_Src, ResultSrc and ALUSrcA/B encodings.
REQ-037 SHALL implement the funct3/funct7b5 to ALUControl mapping as sub-module riscv_alu_decoder.

Verification
REQ-038 Bench SHALL cover: rst held 2 cycles in MEMREAD -> FETCH next cycle, all enables 0 during reset.
REQ-039 Bench SHALL cover: lw (0000011) -> 5-cycle sequence with RegWrite=1 only in cycle 5 and ResultSrc=01.
REQ-040 Bench SHALL cover: beq with zero=1 then zero=0 -> PCWrite=1 then PCWrite=0 in BRANCH, Imm_Src=010.
REQ-041 Bench SHALL cover: sub (0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; addi with funct7b5=1 -> 000.
REQ-042 Bench SHALL cover: jalr -> states JALR1, JALR2, ALUWB with PCWrite=1 only in JALR2 and the FETCH cycle.
REQ-043 Bench SHALL cover: opcode 1111111 -> illegal_op=1 for the DECODE cycle, next state FETCH, no writes.
